// File: rtl/ipm2l_hsstlp_rst_pkg.sv
// Shared types and helpers for the HSSTLP lane reset sequencers.
package ipm2l_hsstlp_rst_pkg;

    localparam int unsigned NUM_LANES = 4;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PMA_RST  = 3'd1,
        ST_WAIT_CDR = 3'd2,
        ST_PCS_RST  = 3'd3,
        ST_DONE     = 3'd4
    } lane_state_e;

    typedef struct packed {
        logic pma_rst;
        logic pcs_rst;
        logic done;
    } lane_out_t;

    // Width holding the largest cycle count plus headroom so nothing can wrap.
    function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b,
                                              input int unsigned c, input int unsigned d);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return $clog2(m) + 1;
    endfunction

    // Moore output decode for a lane state.
    function automatic lane_out_t decode_state(input lane_state_e s);
        lane_out_t o;
        o.pma_rst = (s == ST_IDLE) || (s == ST_PMA_RST);
        o.pcs_rst = (s != ST_DONE);
        o.done    = (s == ST_DONE);
        return o;
    endfunction

endpackage

// File: rtl/ipm2l_hsstlp_rxlane_rst_fsm.sv
// Single RX lane: status synchronisers plus PMA -> CDR -> PCS reset sequencer.
module ipm2l_hsstlp_rxlane_rst_fsm
    import ipm2l_hsstlp_rst_pkg::*;
#(
    parameter int unsigned PMA_RST_CYC     = 16,
    parameter int unsigned CDR_STABLE_CYC  = 64,
    parameter int unsigned CDR_TIMEOUT_CYC = 4096,
    parameter int unsigned PCS_RST_CYC     = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic pll_lock,
    input  logic sigdet,
    input  logic cdr_align,
    input  logic force_rst,
    output logic pma_rst,
    output logic pcs_rst,
    output logic cdr_sync,
    output logic done,
    output logic cdr_timeout
);

    localparam int unsigned CW = cnt_width(PMA_RST_CYC, CDR_STABLE_CYC, CDR_TIMEOUT_CYC, PCS_RST_CYC);
    localparam int unsigned SW = $clog2(CDR_STABLE_CYC) + 1;

    logic        pll_m, pll_q, sig_m, sig_q, cdr_m, cdr_q;
    lane_state_e state, nxt;
    logic [CW-1:0] cnt, cnt_inc;
    logic [SW-1:0] stable, stable_inc;
    logic        restart_c;
    logic        timeout_c;
    lane_out_t   out_nxt;

    // Both counters saturate rather than wrap.
    assign cnt_inc    = (cnt == {CW{1'b1}}) ? cnt : cnt + CW'(1);
    assign stable_inc = (stable >= SW'(CDR_STABLE_CYC)) ? stable : stable + SW'(1);
    assign out_nxt    = decode_state(nxt);
    assign cdr_sync   = cdr_q;

    // Next-state: loss of lock/signal and force override the per-state progress.
    always_comb begin
        nxt       = state;
        restart_c = 1'b0;
        timeout_c = 1'b0;
        if (state == ST_IDLE) begin
            if (pll_q && sig_q && !force_rst) nxt = ST_PMA_RST;
        end else if (!pll_q || !sig_q) begin
            nxt = ST_IDLE;
        end else if (force_rst) begin
            nxt       = ST_PMA_RST;
            restart_c = 1'b1;
        end else begin
            case (state)
                ST_PMA_RST: begin
                    if (cnt_inc == CW'(PMA_RST_CYC)) nxt = ST_WAIT_CDR;
                end
                ST_WAIT_CDR: begin
                    if (cdr_q && (stable_inc >= SW'(CDR_STABLE_CYC))) begin
                        nxt = ST_PCS_RST;
                    end else if (cnt_inc == CW'(CDR_TIMEOUT_CYC)) begin
                        nxt       = ST_PMA_RST;
                        timeout_c = 1'b1;
                    end
                end
                ST_PCS_RST: begin
                    if (!cdr_q) nxt = ST_PMA_RST;
                    else if (cnt_inc == CW'(PCS_RST_CYC)) nxt = ST_DONE;
                end
                ST_DONE: begin
                    if (!cdr_q) nxt = ST_PMA_RST;
                end
                default: nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pll_m       <= 1'b0;
            pll_q       <= 1'b0;
            sig_m       <= 1'b0;
            sig_q       <= 1'b0;
            cdr_m       <= 1'b0;
            cdr_q       <= 1'b0;
            state       <= ST_IDLE;
            cnt         <= '0;
            stable      <= '0;
            pma_rst     <= 1'b1;
            pcs_rst     <= 1'b1;
            done        <= 1'b0;
            cdr_timeout <= 1'b0;
        end else begin
            pll_m       <= pll_lock;
            pll_q       <= pll_m;
            sig_m       <= sigdet;
            sig_q       <= sig_m;
            cdr_m       <= cdr_align;
            cdr_q       <= cdr_m;
            state       <= nxt;
            cnt         <= ((nxt != state) || restart_c) ? '0 : cnt_inc;
            stable      <= ((state == ST_WAIT_CDR) && (nxt == ST_WAIT_CDR) && cdr_q) ? stable_inc : '0;
            pma_rst     <= out_nxt.pma_rst;
            pcs_rst     <= out_nxt.pcs_rst;
            done        <= out_nxt.done;
            cdr_timeout <= timeout_c;
        end
    end

endmodule

// File: rtl/ipm2l_hsstlp_rxlane_rst_v1_3.sv
// Four-lane HSSTLP RX reset sequencer; disabled lanes are tied off in IDLE.
module ipm2l_hsstlp_rxlane_rst_v1_3
    import ipm2l_hsstlp_rst_pkg::*;
#(
    parameter logic [3:0]  RX_LANE_EN      = 4'b1111,
    parameter int unsigned PMA_RST_CYC     = 16,
    parameter int unsigned CDR_STABLE_CYC  = 64,
    parameter int unsigned CDR_TIMEOUT_CYC = 4096,
    parameter int unsigned PCS_RST_CYC     = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_pll_lock,
    input  logic [3:0] i_sigdet,
    input  logic [3:0] i_cdr_align,
    input  logic [3:0] i_force_rxlane_rst,
    output logic [3:0] o_rxlane_pma_rst,
    output logic [3:0] o_rxlane_pcs_rst,
    output logic [3:0] o_cdr_align,
    output logic [3:0] o_rxlane_done,
    output logic [3:0] o_cdr_timeout
);

    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        if (RX_LANE_EN[l]) begin : g_on
            ipm2l_hsstlp_rxlane_rst_fsm #(
                .PMA_RST_CYC    (PMA_RST_CYC),
                .CDR_STABLE_CYC (CDR_STABLE_CYC),
                .CDR_TIMEOUT_CYC(CDR_TIMEOUT_CYC),
                .PCS_RST_CYC    (PCS_RST_CYC)
            ) u_fsm (
                .clk        (clk),
                .rst        (rst),
                .pll_lock   (i_pll_lock),
                .sigdet     (i_sigdet[l]),
                .cdr_align  (i_cdr_align[l]),
                .force_rst  (i_force_rxlane_rst[l]),
                .pma_rst    (o_rxlane_pma_rst[l]),
                .pcs_rst    (o_rxlane_pcs_rst[l]),
                .cdr_sync   (o_cdr_align[l]),
                .done       (o_rxlane_done[l]),
                .cdr_timeout(o_cdr_timeout[l])
            );
        end else begin : g_off
            logic lane_unused;
            assign lane_unused         = ^{i_sigdet[l], i_cdr_align[l], i_force_rxlane_rst[l]};
            assign o_rxlane_pma_rst[l] = 1'b1;
            assign o_rxlane_pcs_rst[l] = 1'b1;
            assign o_cdr_align[l]      = 1'b0;
            assign o_rxlane_done[l]    = 1'b0;
            assign o_cdr_timeout[l]    = 1'b0;
        end
    end

endmodule

// File: tb/tb_ipm2l_hsstlp_rxlane_rst_v1_3.sv
// Bench: edge-indexed vector table, directed corner sequences, and random stimulus vs a lane model.
module tb_ipm2l_hsstlp_rxlane_rst_v1_3;

    localparam int P_PMA = 4;
    localparam int P_STB = 8;
    localparam int P_TO  = 32;
    localparam int P_PCS = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       i_pll_lock = 1'b0;
    logic [3:0] i_sigdet = '0, i_cdr_align = '0, i_force_rxlane_rst = '0;
    logic [3:0] o_pma, o_pcs, o_cdr, o_done, o_tout;
    logic [3:0] d_pma, d_pcs, d_cdr, d_done, d_tout;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ipm2l_hsstlp_rxlane_rst_v1_3 #(
        .RX_LANE_EN(4'b1111), .PMA_RST_CYC(P_PMA), .CDR_STABLE_CYC(P_STB),
        .CDR_TIMEOUT_CYC(P_TO), .PCS_RST_CYC(P_PCS)
    ) dut (
        .clk(clk), .rst(rst), .i_pll_lock(i_pll_lock), .i_sigdet(i_sigdet),
        .i_cdr_align(i_cdr_align), .i_force_rxlane_rst(i_force_rxlane_rst),
        .o_rxlane_pma_rst(o_pma), .o_rxlane_pcs_rst(o_pcs), .o_cdr_align(o_cdr),
        .o_rxlane_done(o_done), .o_cdr_timeout(o_tout)
    );

    ipm2l_hsstlp_rxlane_rst_v1_3 #(
        .RX_LANE_EN(4'b0111), .PMA_RST_CYC(P_PMA), .CDR_STABLE_CYC(P_STB),
        .CDR_TIMEOUT_CYC(P_TO), .PCS_RST_CYC(P_PCS)
    ) dut_dis (
        .clk(clk), .rst(rst), .i_pll_lock(i_pll_lock), .i_sigdet(i_sigdet),
        .i_cdr_align(i_cdr_align), .i_force_rxlane_rst(i_force_rxlane_rst),
        .o_rxlane_pma_rst(d_pma), .o_rxlane_pcs_rst(d_pcs), .o_cdr_align(d_cdr),
        .o_rxlane_done(d_done), .o_cdr_timeout(d_tout)
    );

    // Reference model: phase 0..4 = idle, pma reset, wait cdr, pcs reset, done.
    int         ph[4], age[4], run[4];
    logic       pl_a, pl_b;
    logic [3:0] sd_a, sd_b, cd_a, cd_b;
    logic [3:0] m_pma, m_pcs, m_done, m_cdr, m_tout;

    task automatic model_out();
        for (int l = 0; l < 4; l++) begin
            m_pma[l]  = (ph[l] <= 1);
            m_pcs[l]  = (ph[l] <= 3);
            m_done[l] = (ph[l] == 4);
        end
        m_cdr = cd_b;
    endtask

    task automatic model_reset();
        for (int l = 0; l < 4; l++) begin
            ph[l] = 0; age[l] = 0; run[l] = 0;
        end
        pl_a = 0; pl_b = 0; sd_a = '0; sd_b = '0; cd_a = '0; cd_b = '0;
        m_tout = '0;
        model_out();
    endtask

    task automatic model_step();
        int np;
        bit restart;
        m_tout = '0;
        for (int l = 0; l < 4; l++) begin
            np = ph[l];
            restart = 0;
            if (ph[l] == 0) begin
                if (pl_b && sd_b[l] && !i_force_rxlane_rst[l]) np = 1;
            end else if (!pl_b || !sd_b[l]) begin
                np = 0;
            end else if (i_force_rxlane_rst[l]) begin
                np = 1; restart = 1;
            end else if (ph[l] == 1) begin
                if (age[l] + 1 == P_PMA) np = 2;
            end else if (ph[l] == 2) begin
                if (cd_b[l] && run[l] + 1 >= P_STB) np = 3;
                else if (age[l] + 1 == P_TO) begin np = 1; m_tout[l] = 1'b1; end
            end else if (ph[l] == 3) begin
                if (!cd_b[l]) np = 1;
                else if (age[l] + 1 == P_PCS) np = 4;
            end else begin
                if (!cd_b[l]) np = 1;
            end
            if (np != ph[l] || restart) begin
                age[l] = 0; run[l] = 0;
            end else begin
                age[l] = age[l] + 1;
                run[l] = cd_b[l] ? run[l] + 1 : 0;
            end
            ph[l] = np;
        end
        pl_b = pl_a; pl_a = i_pll_lock;
        sd_b = sd_a; sd_a = i_sigdet;
        cd_b = cd_a; cd_a = i_cdr_align;
        model_out();
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0t act=%h exp=%h", name, $time, act, exp);
        end
    endtask

    task automatic cmp_model();
        chk("model_pma", 32'(o_pma), 32'(m_pma));
        chk("model_pcs", 32'(o_pcs), 32'(m_pcs));
        chk("model_done", 32'(o_done), 32'(m_done));
        chk("model_cdr", 32'(o_cdr), 32'(m_cdr));
        chk("model_tout", 32'(o_tout), 32'(m_tout));
        chk("dis_pma", 32'(d_pma), 32'(m_pma | 4'b1000));
        chk("dis_pcs", 32'(d_pcs), 32'(m_pcs | 4'b1000));
        chk("dis_done", 32'(d_done), 32'(m_done & 4'b0111));
        chk("dis_cdr", 32'(d_cdr), 32'(m_cdr & 4'b0111));
        chk("dis_tout", 32'(d_tout), 32'(m_tout & 4'b0111));
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) model_reset();
        else model_step();
        #1;
        cmp_model();
    endtask

    task automatic do_reset(input logic pll, input logic [3:0] sd, input logic [3:0] cd);
        rst = 1'b1;
        i_pll_lock = pll; i_sigdet = sd; i_cdr_align = cd; i_force_rxlane_rst = '0;
        model_reset();
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic rand_drive();
        if (i_pll_lock) begin
            if ($urandom_range(0, 999) < 1) i_pll_lock = 1'b0;
        end else if ($urandom_range(0, 99) < 10) i_pll_lock = 1'b1;
        for (int l = 0; l < 4; l++) begin
            if (i_sigdet[l]) begin
                if ($urandom_range(0, 999) < 3) i_sigdet[l] = 1'b0;
            end else if ($urandom_range(0, 99) < 5) i_sigdet[l] = 1'b1;
            if (i_cdr_align[l]) begin
                if ($urandom_range(0, 99) < 1) i_cdr_align[l] = 1'b0;
            end else if ($urandom_range(0, 99) < 3) i_cdr_align[l] = 1'b1;
            if (i_force_rxlane_rst[l]) begin
                if ($urandom_range(0, 99) < 20) i_force_rxlane_rst[l] = 1'b0;
            end else if ($urandom_range(0, 999) < 2) i_force_rxlane_rst[l] = 1'b1;
        end
    endtask

    typedef struct {
        int         edge_n;
        logic [3:0] pma, pcs, done, cdr, tout;
    } vec_t;

    vec_t tbl[10];
    int   pulses;

    initial begin
        // Bring-up expectations, edges counted from rst release.
        tbl[0] = '{1,  4'hF, 4'hF, 4'h0, 4'h0, 4'h0};
        tbl[1] = '{2,  4'hF, 4'hF, 4'h0, 4'hF, 4'h0};
        tbl[2] = '{3,  4'hF, 4'hF, 4'h0, 4'hF, 4'h0};
        tbl[3] = '{6,  4'hF, 4'hF, 4'h0, 4'hF, 4'h0};
        tbl[4] = '{7,  4'h0, 4'hF, 4'h0, 4'hF, 4'h0};
        tbl[5] = '{14, 4'h0, 4'hF, 4'h0, 4'hF, 4'h0};
        tbl[6] = '{15, 4'h0, 4'hF, 4'h0, 4'hF, 4'h0};
        tbl[7] = '{18, 4'h0, 4'hF, 4'h0, 4'hF, 4'h0};
        tbl[8] = '{19, 4'h0, 4'h0, 4'hF, 4'hF, 4'h0};
        tbl[9] = '{25, 4'h0, 4'h0, 4'hF, 4'hF, 4'h0};

        model_reset();
        tick();
        chk("reset_pma", 32'(o_pma), 32'hF);
        chk("reset_pcs", 32'(o_pcs), 32'hF);
        chk("reset_done", 32'(o_done), 32'h0);
        chk("reset_cdr", 32'(o_cdr), 32'h0);
        chk("reset_tout", 32'(o_tout), 32'h0);

        // Bring-up
        do_reset(1'b1, 4'hF, 4'hF);
        for (int e = 1; e <= 25; e++) begin
            tick();
            for (int k = 0; k < 10; k++) begin
                if (tbl[k].edge_n == e) begin
                    chk($sformatf("bringup_pma_e%0d", e), 32'(o_pma), 32'(tbl[k].pma));
                    chk($sformatf("bringup_pcs_e%0d", e), 32'(o_pcs), 32'(tbl[k].pcs));
                    chk($sformatf("bringup_done_e%0d", e), 32'(o_done), 32'(tbl[k].done));
                    chk($sformatf("bringup_cdr_e%0d", e), 32'(o_cdr), 32'(tbl[k].cdr));
                    chk($sformatf("bringup_tout_e%0d", e), 32'(o_tout), 32'(tbl[k].tout));
                end
            end
        end
        chk("disabled_pma", 32'(d_pma), 32'h8);
        chk("disabled_done", 32'(d_done), 32'h7);
        chk("disabled_cdr", 32'(d_cdr), 32'h7);

        // CDR timeout on lane 1
        do_reset(1'b1, 4'hF, 4'b1101);
        pulses = 0;
        for (int e = 1; e <= 120; e++) begin
            tick();
            if (o_tout[1]) pulses++;
            chk($sformatf("timeout_pulse_e%0d", e), 32'(o_tout[1]),
                32'((e >= 39) && ((e - 39) % 36 == 0)));
            chk($sformatf("timeout_pma_e%0d", e), 32'(o_pma[1]),
                32'((e < 7) || ((e >= 39) && ((e - 39) % 36 < 4))));
        end
        chk("timeout_pulse_count", 32'(pulses), 32'd3);
        chk("timeout_other_done", 32'(o_done), 32'hD);

        // Single-cycle CDR glitch on lane 0 at stable count 6
        do_reset(1'b1, 4'hF, 4'hF);
        for (int e = 1; e <= 30; e++) begin
            tick();
            if (e == 11) i_cdr_align[0] = 1'b0;
            if (e == 12) i_cdr_align[0] = 1'b1;
            if (e == 13) chk("glitch_cdr_low", 32'(o_cdr), 32'hE);
            if (e == 14) chk("glitch_cdr_back", 32'(o_cdr), 32'hF);
            if (e == 19) chk("glitch_others_done", 32'(o_done), 32'hE);
            if (e == 25) chk("glitch_not_yet", 32'(o_done), 32'hE);
            if (e == 26) chk("glitch_done", 32'(o_done), 32'hF);
        end

        // Signal-detect loss on lane 2 while DONE
        i_sigdet[2] = 1'b0;
        for (int n = 1; n <= 30; n++) begin
            tick();
            if (n == 10) i_sigdet[2] = 1'b1;
            if (n == 2) chk("sigdet_still_done", 32'(o_done), 32'hF);
            if (n == 3) begin
                chk("sigdet_done_drop", 32'(o_done), 32'hB);
                chk("sigdet_pma", 32'(o_pma), 32'h4);
                chk("sigdet_pcs", 32'(o_pcs), 32'h4);
            end
            if (n == 28) chk("sigdet_not_yet", 32'(o_done), 32'hB);
            if (n == 29) chk("sigdet_redone", 32'(o_done), 32'hF);
        end

        // Force on lane 0 while DONE, held 5 cycles
        i_force_rxlane_rst[0] = 1'b1;
        for (int n = 1; n <= 22; n++) begin
            tick();
            if (n == 5) i_force_rxlane_rst[0] = 1'b0;
            if (n == 1) begin
                chk("force_pma", 32'(o_pma), 32'h1);
                chk("force_done", 32'(o_done), 32'hE);
            end
            if (n == 8) chk("force_pma_hold", 32'(o_pma), 32'h1);
            if (n == 9) chk("force_pma_rel", 32'(o_pma), 32'h0);
            if (n == 20) chk("force_not_yet", 32'(o_done), 32'hE);
            if (n == 21) chk("force_redone", 32'(o_done), 32'hF);
        end

        // PLL loss while DONE
        i_pll_lock = 1'b0;
        for (int n = 1; n <= 4; n++) begin
            tick();
            if (n == 2) chk("pll_still_done", 32'(o_done), 32'hF);
            if (n == 3) begin
                chk("pll_done_drop", 32'(o_done), 32'h0);
                chk("pll_pma", 32'(o_pma), 32'hF);
            end
        end

        // Async reset in WAIT_CDR
        do_reset(1'b1, 4'hF, 4'hF);
        for (int e = 1; e <= 10; e++) tick();
        chk("wait_cdr_pma", 32'(o_pma), 32'h0);
        rst = 1'b1;
        model_reset();
        #2;
        chk("async_pma", 32'(o_pma), 32'hF);
        chk("async_pcs", 32'(o_pcs), 32'hF);
        chk("async_done", 32'(o_done), 32'h0);
        chk("async_cdr", 32'(o_cdr), 32'h0);
        chk("async_tout", 32'(o_tout), 32'h0);
        cmp_model();
        tick();
        tick();

        // Random stimulus against the model
        do_reset(1'b1, 4'hF, 4'hF);
        for (int c = 0; c < 3000; c++) begin
            tick();
            rand_drive();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ipm2l_hsstlp_rxlane_rst_v1_3.md
# ipm2l_hsstlp_rxlane_rst_v1_3

Per-lane HSSTLP receive reset sequencer. It sits directly upstream of the RX FIFO-clear stage and produces that stage's `cdr_align` and `rxlane_done` inputs. For each enabled lane it synchronises the raw PMA status and walks a PMA-reset → CDR-lock → PCS-reset sequence. It re-sequences the lane on loss of PLL lock, signal, or CDR alignment.

## Interface
- `RX_LANE_EN`, 4'b1111: per-lane enable. A disabled lane is held in IDLE.
- `PMA_RST_CYC`, 16: cycles the lane stays in PMA_RST (≥1).
- `CDR_STABLE_CYC`, 64: consecutive synced-cdr-high cycles required in WAIT_CDR (≥1).
- `CDR_TIMEOUT_CYC`, 4096: maximum cycles in WAIT_CDR before retry (> CDR_STABLE_CYC).
- `PCS_RST_CYC`, 16: cycles the lane stays in PCS_RST (≥1).
- `clk` in 1: free-running reference clock. Single clock domain.
- `rst` in 1: asynchronous, active-high reset for all flops.
- `i_pll_lock` in 1: TX/RX PLL lock, asynchronous.
- `i_sigdet` in 4: per-lane signal detect, asynchronous.
- `i_cdr_align` in 4: per-lane raw CDR align, asynchronous.
- `i_force_rxlane_rst` in 4: user re-sequence request, synchronous to clk, level-sensitive.
- `o_rxlane_pma_rst` out 4: PMA RX reset, active-high.
- `o_rxlane_pcs_rst` out 4: PCS RX reset, active-high.
- `o_cdr_align` out 4: synchronised CDR align. Feeds the FIFO-clear stage.
- `o_rxlane_done` out 4: lane ready. Feeds the FIFO-clear stage.
- `o_cdr_timeout` out 4: one-cycle pulse on each WAIT_CDR timeout.

## Operation
- Synchronisers: `i_pll_lock`, `i_sigdet` and `i_cdr_align` each pass through a 2-flop synchroniser that resets to 0. The FSM uses only the synced values.
- `o_cdr_align` equals the synced cdr value ANDed with `RX_LANE_EN`.
- Each lane runs its own FSM with states IDLE, PMA_RST, WAIT_CDR, PCS_RST, DONE.
- Outputs are Moore-decoded from the registered state:
  - IDLE, PMA_RST: pma=1, pcs=1, done=0.
  - WAIT_CDR, PCS_RST: pma=0, pcs=1, done=0.
  - DONE: pma=0, pcs=0, done=1.
- IDLE → PMA_RST when synced pll_lock and synced sigdet are both 1 and force=0.
- PMA_RST → WAIT_CDR after exactly PMA_RST_CYC cycles in the state.
- WAIT_CDR:
  - A stable counter clears whenever synced cdr=0.
  - → PCS_RST when the stable counter reaches CDR_STABLE_CYC.
  - → PMA_RST when the timeout counter reaches CDR_TIMEOUT_CYC, with `o_cdr_timeout` pulsed for 1 cycle.
  - If stable and timeout are reached in the same cycle, stable wins and no pulse is issued.
- PCS_RST → DONE after exactly PCS_RST_CYC cycles. If synced cdr drops during PCS_RST, go → PMA_RST.
- Exit priority from any non-IDLE state, evaluated every cycle:
  1. synced pll_lock=0 → IDLE
  2. synced sigdet=0 → IDLE
  3. force=1 → PMA_RST
  4. In DONE only: synced cdr=0 → PMA_RST
- Counters:
  - A single per-lane counter, sized by `$clog2` of the largest parameter plus 1, is cleared on every state entry.
  - The stable counter is separate and saturates.
  - No wrap-around is possible.
- Disabled lane: held permanently in IDLE with pma=1, pcs=1, done=0, timeout=0, cdr=0.

## Timing
- Reset values: `o_rxlane_pma_rst`=4'hF, `o_rxlane_pcs_rst`=4'hF, `o_rxlane_done`=0, `o_cdr_align`=0, `o_cdr_timeout`=0. All counters are 0 and every FSM is in IDLE.
- Asynchronous input to FSM decision: 2-cycle synchroniser latency plus 1 cycle for the state register.
- "N cycles in state" means N rising edges are spent in that state.
- Best-case bring-up latency, with all inputs high through rst release: DONE, and therefore `o_rxlane_done`, is reached on edge 3 + PMA_RST_CYC + CDR_STABLE_CYC + PCS_RST_CYC.
- `rst` asserted mid-sequence: all outputs return to their reset values immediately, with no clk needed.
- `i_force_rxlane_rst` held high keeps the lane in PMA_RST with its counter continuously cleared. The sequence resumes on the first cycle after it is released.

## Structure
- Shared package `ipm2l_hsstlp_rst_pkg` contains:
  - FSM state enum/localparams: IDLE=0, PMA_RST=1, WAIT_CDR=2, PCS_RST=3, DONE=4.
  - A counter-width function.
- Sub-module `ipm2l_hsstlp_rxlane_rst_fsm`: single-lane synchronisers, FSM and counters. It is instantiated 4× in a generate loop, with tie-off when the lane is disabled.
- Top level contains only the instances, `i_pll_lock` fan-out and `RX_LANE_EN` gating.

## Test plan
All scenarios use PMA_RST_CYC=4, CDR_STABLE_CYC=8, CDR_TIMEOUT_CYC=32, PCS_RST_CYC=4, RX_LANE_EN=4'b1111.

- **Bring-up:** all inputs high through rst release → pma falls on edge 7, pcs falls and done rises on edge 19, all lanes together.
- **CDR timeout:** lane 1 cdr held 0 → `o_cdr_timeout[1]` pulses once every 36 cycles; `o_rxlane_pma_rst[1]` re-asserts for 4 cycles each time; lanes 0, 2 and 3 reach done.
- **Glitchy CDR:** cdr drops for 1 cycle at stable count 6 → stable count restarts; done is delayed by 7 cycles relative to the clean case.
- **Loss in DONE:** `i_sigdet[2]`=0 for 10 cycles → done[2]=0 and pma[2]=pcs[2]=1 from 3 cycles after the drop; done[2] is re-achieved 3+16 cycles after sigdet returns.
- **PLL loss and async reset:**
  - `i_pll_lock` falling in DONE → all done=0 after 3 cycles.
  - `rst` pulsed mid-WAIT_CDR → outputs are at reset values before the next edge.
- **Disabled lane and force:**
  - RX_LANE_EN=4'b0111 → lane 3 stays pma=pcs=1, done=0, `o_cdr_align[3]`=0 regardless of inputs.
  - Force on lane 0 in DONE → PMA_RST on the next edge; done returns 16 cycles after release.
